// File: rtl/alu_multicycle.sv
// Multi-cycle EX-stage ALU: registered result with start/busy/done handshake.
// Define ALU_MULDIV_EN to build the iterative shift-add multiplier and restoring divider.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [OPW-1:0]   ALUop,
  output logic [WIDTH-1:0] ALURes,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
  localparam logic [OPW-1:0] OP_AND  = OPW'(3);
  localparam logic [OPW-1:0] OP_OR   = OPW'(4);
  localparam logic [OPW-1:0] OP_SLTU = OPW'(5);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(6);
  localparam logic [OPW-1:0] OP_NOR  = OPW'(7);
  localparam logic [OPW-1:0] OP_SLL  = OPW'(8);
  localparam logic [OPW-1:0] OP_SRL  = OPW'(9);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] single_res;

`ifdef ALU_MULDIV_EN
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [OPW-1:0] OP_MUL  = OPW'(10);
  localparam logic [OPW-1:0] OP_DIVU = OPW'(11);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] wrk_hi_q, wrk_hi_d;
  logic [WIDTH-1:0] wrk_lo_q, wrk_lo_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;

  // One iteration: multiply keeps {hi,lo} as partial product / remaining multiplier,
  // divide keeps {hi,lo} as partial remainder / dividend-then-quotient.
  always_comb begin
    mul_sum   = {1'b0, wrk_hi_q} + (wrk_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    div_shift = {wrk_hi_q, wrk_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_diff  = div_shift[WIDTH-1:0] - opb_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {wrk_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], wrk_lo_q[WIDTH-1:1]};
    end
  end
`endif

  always_comb begin
    single_res = '0;
    case (ALUop)
      OP_ADD:  single_res = input1 + input2;
      OP_SUB:  single_res = input1 - input2;
      OP_AND:  single_res = input1 & input2;
      OP_OR:   single_res = input1 | input2;
      OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (input1 < input2)};
      OP_XOR:  single_res = input1 ^ input2;
      OP_NOR:  single_res = ~(input1 | input2);
      OP_SLL:  single_res = input1 << input2[SHW-1:0];
      OP_SRL:  single_res = input1 >> input2[SHW-1:0];
      default: single_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    hi_d    = hi_q;
`ifdef ALU_MULDIV_EN
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opb_d    = opb_q;
    wrk_hi_d = wrk_hi_q;
    wrk_lo_d = wrk_lo_q;
`endif
    case (state_q)
`ifdef ALU_MULDIV_EN
      ST_CALC: begin
        wrk_hi_d = step_hi;
        wrk_lo_d = step_lo;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          res_d   = step_lo;
          hi_d    = step_hi;
        end
      end
`endif
      // IDLE and DONE both accept a new operation, which gives back-to-back issue.
      default: begin
        if (start) begin
`ifdef ALU_MULDIV_EN
          if (ALUop == OP_MUL || ALUop == OP_DIVU) begin
            state_d  = ST_CALC;
            cnt_d    = CW'(WIDTH);
            is_div_d = (ALUop == OP_DIVU);
            opb_d    = (ALUop == OP_DIVU) ? input2 : input1;
            wrk_hi_d = '0;
            wrk_lo_d = (ALUop == OP_DIVU) ? input1 : input2;
          end else
`endif
          begin
            state_d = ST_DONE;
            res_d   = single_res;
            hi_d    = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      res_q    <= '0;
      hi_q     <= '0;
`ifdef ALU_MULDIV_EN
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opb_q    <= '0;
      wrk_hi_q <= '0;
      wrk_lo_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      hi_q     <= hi_d;
`ifdef ALU_MULDIV_EN
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opb_q    <= opb_d;
      wrk_hi_q <= wrk_hi_d;
      wrk_lo_q <= wrk_lo_d;
`endif
    end
  end

  assign ALURes = res_q;
  assign hi     = hi_q;
  assign zero   = (res_q == '0);
  assign done   = (state_q == ST_DONE);
`ifdef ALU_MULDIV_EN
  assign busy   = (state_q == ST_CALC);
`else
  assign busy   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: cycle-by-cycle compare against a timing/arithmetic model
// plus directed vectors with literal expectations. Honours ALU_MULDIV_EN like the DUT.
module tb_alu_multicycle;

  localparam int W = 32;
`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  localparam logic [3:0] OP_ZERO = 4'd0,  OP_ADD = 4'd1,  OP_SUB  = 4'd2,  OP_AND = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4,  OP_SLTU = 4'd5, OP_XOR  = 4'd6,  OP_NOR = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8,  OP_SRL = 4'd9,  OP_MUL  = 4'd10, OP_DIVU = 4'd11;
  localparam logic [3:0] OP_BAD  = 4'd15;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] input1 = '0;
  logic [W-1:0] input2 = '0;
  logic [3:0]   ALUop = '0;
  logic [W-1:0] ALURes, hi;
  logic         zero, busy, done;

  alu_multicycle #(.WIDTH(W), .OPW(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .input1(input1), .input2(input2), .ALUop(ALUop),
    .ALURes(ALURes), .hi(hi), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  // model state: at most one operation in flight, plus the last completed result
  bit           pend_valid = 1'b0;
  bit           pend_multi = 1'b0;
  int           pend_n = 0, pend_due = 0, last_acc = 0;
  logic [W-1:0] pend_res = '0, pend_hi = '0, last_res = '0, last_hi = '0;
  bit           chk_en = 1'b0;
  bit           e_done, e_busy;
  int           busy_cnt = 0, done_cnt = 0;
  int           n_checks = 0, n_pass = 0;

  function automatic void ref_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] r, output logic [W-1:0] h, output bit multi);
    r = '0;
    h = '0;
    multi = 1'b0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SLL:  r = a << (b % 32);
      OP_SRL:  r = a >> (b % 32);
`ifdef ALU_MULDIV_EN
      OP_MUL: begin
        logic [2*W-1:0] p;
        p = {32'd0, a} * {32'd0, b};
        r = p[W-1:0];
        h = p[2*W-1:W];
        multi = 1'b1;
      end
      OP_DIVU: begin
        multi = 1'b1;
        if (b == 0) begin
          r = '1;
          h = a;
        end else begin
          r = a / b;
          h = a % b;
        end
      end
`endif
      default: ;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, want, $time);
  endtask

  // Pulse start for one edge; the model accepts only if nothing is still in flight.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r, h;
    bit m;
    ALUop  = op;
    input1 = a;
    input2 = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    input1 = $urandom;
    input2 = $urandom;
    ALUop  = 4'($urandom);
    if (!pend_valid || edge_n > pend_due) begin
      ref_model(op, a, b, r, h, m);
      pend_valid = 1'b1;
      pend_multi = m;
      pend_n     = edge_n;
      pend_due   = edge_n + (m ? W : 0);
      pend_res   = r;
      pend_hi    = h;
      last_acc   = edge_n;
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    pend_valid = 1'b0;
    last_res   = '0;
    last_hi    = '0;
  endtask

  task automatic waitDone(output int lat);
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = edge_n - last_acc;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++;
      $display("[TB] FAIL done_timeout: no done within 200 cycles, expected one");
    end
  endtask

  // Every cycle: handshake outputs and held results must match the model.
  always @(negedge clk) begin
    if (chk_en) begin
      e_done = pend_valid && (edge_n == pend_due);
      e_busy = pend_valid && pend_multi && (edge_n >= pend_n) && (edge_n < pend_due);
      if (e_done) begin
        last_res   = pend_res;
        last_hi    = pend_hi;
        pend_valid = 1'b0;
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      checkOutput("cyc_done", 32'(done), 32'(e_done));
      checkOutput("cyc_busy", 32'(busy), 32'(e_busy));
      checkOutput("cyc_ALURes", ALURes, last_res);
      checkOutput("cyc_hi", hi, last_hi);
      checkOutput("cyc_zero", 32'(zero), 32'(last_res == '0));
    end
  end

  logic [3:0]   s_op [10] = '{OP_SLTU, OP_SLTU, OP_SLL, OP_SRL, OP_NOR, OP_XOR, OP_AND, OP_OR, OP_ZERO, OP_BAD};
  logic [W-1:0] s_a  [10] = '{32'd3, 32'hFFFFFFFF, 32'd1, 32'h80000000, 32'd0,
                              32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h1234, 32'h1234};
  logic [W-1:0] s_b  [10] = '{32'hFFFFFFFF, 32'd3, 32'd31, 32'd33, 32'd0,
                              32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'd1, 32'd1};
  logic [W-1:0] s_r  [10] = '{32'd1, 32'd0, 32'h80000000, 32'h40000000, 32'hFFFFFFFF,
                              32'h0FF00FF0, 32'hF000F000, 32'hFFF0FFF0, 32'd0, 32'd0};

  logic [3:0]   m_op [4] = '{OP_DIVU, OP_DIVU, OP_MUL, OP_MUL};
  logic [W-1:0] m_a  [4] = '{32'd100, 32'h1234, 32'd3, 32'h00010000};
  logic [W-1:0] m_b  [4] = '{32'd7, 32'd0, 32'd4, 32'h00010000};
  logic [W-1:0] m_r  [4] = '{32'd14, 32'hFFFFFFFF, 32'd12, 32'd0};
  logic [W-1:0] m_h  [4] = '{32'd2, 32'h1234, 32'd0, 32'd1};

  initial begin
    int lat, busy_snap, done_snap;

    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    checkOutput("rst_ALURes", ALURes, 32'd0);
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_zero", 32'(zero), 32'd1);

    // reset three cycles into a multiply: everything clears, no done afterwards
    applyStimulus(OP_ADD, 32'd2, 32'd3);
    @(negedge clk);
    checkOutput("pre_add_ALURes", ALURes, 32'd5);
    applyStimulus(OP_MUL, 32'd5, 32'd6);
    @(posedge clk);
    @(posedge clk);
    #1;
    applyReset();
    @(negedge clk);
    checkOutput("abort_ALURes", ALURes, 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_zero", 32'(zero), 32'd1);
    done_snap = done_cnt;
    repeat (40) @(negedge clk);
    checkOutput("abort_no_done", 32'(done_cnt - done_snap), 32'd0);

    // ADD wrap then SUB issued in the DONE cycle
    applyStimulus(OP_ADD, 32'hFFFFFFFF, 32'd1);
    @(negedge clk);
    checkOutput("add_done", 32'(done), 32'd1);
    checkOutput("add_ALURes", ALURes, 32'd0);
    checkOutput("add_zero", 32'(zero), 32'd1);
    applyStimulus(OP_SUB, 32'd5, 32'd7);
    @(negedge clk);
    checkOutput("sub_done", 32'(done), 32'd1);
    checkOutput("sub_ALURes", ALURes, 32'hFFFFFFFE);
    checkOutput("sub_zero", 32'(zero), 32'd0);
    checkOutput("sub_hi", hi, 32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(s_op[i], s_a[i], s_b[i]);
      waitDone(lat);
      checkOutput($sformatf("single%0d_lat", i), 32'(lat), 32'd0);
      checkOutput($sformatf("single%0d_ALURes", i), ALURes, s_r[i]);
      checkOutput($sformatf("single%0d_hi", i), hi, 32'd0);
    end

    // full-range multiply with an ignored start while busy
    repeat (2) @(negedge clk);
    busy_snap = busy_cnt;
    done_snap = done_cnt;
    applyStimulus(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
`ifdef ALU_MULDIV_EN
    repeat (3) @(negedge clk);
    applyStimulus(OP_ADD, 32'd1, 32'd1);
`endif
    waitDone(lat);
    checkOutput("mulmax_lat", 32'(lat), MD ? 32'd32 : 32'd0);
    checkOutput("mulmax_ALURes", ALURes, MD ? 32'h00000001 : 32'd0);
    checkOutput("mulmax_hi", hi, MD ? 32'hFFFFFFFE : 32'd0);
    checkOutput("mulmax_zero", 32'(zero), MD ? 32'd0 : 32'd1);
    repeat (5) @(negedge clk);
    checkOutput("mulmax_busy_cycles", 32'(busy_cnt - busy_snap), MD ? 32'd32 : 32'd0);
    checkOutput("mulmax_done_pulses", 32'(done_cnt - done_snap), 32'd1);

    for (int i = 0; i < 4; i++) begin
      busy_snap = busy_cnt;
      applyStimulus(m_op[i], m_a[i], m_b[i]);
      waitDone(lat);
      checkOutput($sformatf("muldiv%0d_lat", i), 32'(lat), MD ? 32'd32 : 32'd0);
      checkOutput($sformatf("muldiv%0d_ALURes", i), ALURes, MD ? m_r[i] : 32'd0);
      checkOutput($sformatf("muldiv%0d_hi", i), hi, MD ? m_h[i] : 32'd0);
      checkOutput($sformatf("muldiv%0d_busy_cycles", i), 32'(busy_cnt - busy_snap), MD ? 32'd32 : 32'd0);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
